// File: rtl/ahb_mux_pkg.sv
// Shared types and constants for the AHB data-phase response controller.
package ahb_mux_pkg;

  typedef logic [1:0] ds_state_t;

  localparam ds_state_t DS_IDLE = 2'd0;
  localparam ds_state_t DS_ERR1 = 2'd1;
  localparam ds_state_t DS_ERR2 = 2'd2;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // True for transfer types that demand a real response from the addressed slave.
  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle ERROR response for unmapped active transfers, or on a watchdog abort.
module ahb_default_slave
  import ahb_mux_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic accept_i,
  input  logic unmapped_req_i,
  input  logic timeout_i,
  output logic ds_ready_o,
  output logic ds_resp_o,
  output logic idle_o,
  output logic timeout_err_o
);

  ds_state_t state_q, state_d;
  logic      to_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DS_IDLE: if (timeout_i || (accept_i && unmapped_req_i)) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: state_d = (accept_i && unmapped_req_i) ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DS_IDLE;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      to_q    <= timeout_i && (state_q == DS_IDLE);
    end
  end

  assign ds_ready_o    = (state_q != DS_ERR1);
  assign ds_resp_o     = (state_q == DS_IDLE) ? HRESP_OKAY : HRESP_ERROR;
  assign idle_o        = (state_q == DS_IDLE);
  // Only set on the edge entering DS_ERR1 from a watchdog abort, so it pulses in that cycle.
  assign timeout_err_o = to_q;

endmodule

// File: rtl/ahb_resp_mux_ctrl.sv
// AHB data-phase response mux with built-in default slave.
// Optional slave wait-state watchdog enabled by defining AHB_RESP_MUX_TIMEOUT_EN.
module ahb_resp_mux_ctrl
  import ahb_mux_pkg::*;
#(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MASTER_WIDTH   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                             Hclk,
  input  logic                             Hreset,
  input  logic [NUM_SLAVES-1:0]            Hsel_in,
  input  logic [1:0]                       Htrans,
  input  logic [MASTER_WIDTH-1:0]          Hmaster_in,
  input  logic [NUM_SLAVES-1:0]            Hreadyout_s,
  input  logic [NUM_SLAVES-1:0]            Hresp_s,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] Hrdata_s,
  output logic                             Hready,
  output logic                             Hresp,
  output logic [DATA_WIDTH-1:0]            Hrdata,
  output logic [MASTER_WIDTH-1:0]          Hmaster_data,
  output logic                             timeout_err
);

  localparam int unsigned SelW = $clog2(NUM_SLAVES + 1);
  // Index NUM_SLAVES encodes the default slave.
  localparam logic [SelW-1:0] SelDefault = SelW'(NUM_SLAVES);

  logic [SelW-1:0]         dsel_q, dsel_d, sel_idx;
  logic [MASTER_WIDTH-1:0] master_q, master_d;
  logic                    slv_ready, slv_resp;
  logic [DATA_WIDTH-1:0]   slv_rdata;
  logic                    ds_ready, ds_resp, ds_idle, ds_timeout_err;
  logic                    unmapped_req, use_ds, timeout_fire;

  // Lowest set select bit wins on a multi-hot decode.
  always_comb begin
    sel_idx = SelDefault;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (Hsel_in[i]) sel_idx = SelW'(i);
    end
  end

  assign unmapped_req = (Hsel_in == '0) && is_active(Htrans);

  always_comb begin
    dsel_d   = dsel_q;
    master_d = master_q;
    if (Hready) begin
      dsel_d   = sel_idx;
      master_d = Hmaster_in;
    end
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      dsel_q   <= SelDefault;
      master_q <= '0;
    end else begin
      dsel_q   <= dsel_d;
      master_q <= master_d;
    end
  end

  always_comb begin
    slv_ready = 1'b1;
    slv_resp  = HRESP_OKAY;
    slv_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel_q == SelW'(i)) begin
        slv_ready = Hreadyout_s[i];
        slv_resp  = Hresp_s[i];
        slv_rdata = Hrdata_s[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A busy default slave while a decoded slave is selected means a watchdog abort is in progress.
  assign use_ds = (dsel_q == SelDefault) || !ds_idle;

`ifdef AHB_RESP_MUX_TIMEOUT_EN
  logic [7:0] wait_q, wait_d;
  logic       stall;

  assign stall        = !use_ds && !slv_ready;
  assign timeout_fire = stall && (wait_q == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wait_d = wait_q;
    if (Hready || timeout_fire) begin
      wait_d = '0;
    end else if (stall) begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign timeout_fire = 1'b0;
`endif

  ahb_default_slave u_default_slave (
    .clk_i          (Hclk),
    .rst_i          (Hreset),
    .accept_i       (Hready),
    .unmapped_req_i (unmapped_req),
    .timeout_i      (timeout_fire),
    .ds_ready_o     (ds_ready),
    .ds_resp_o      (ds_resp),
    .idle_o         (ds_idle),
    .timeout_err_o  (ds_timeout_err)
  );

  assign Hready       = use_ds ? ds_ready : slv_ready;
  assign Hresp        = use_ds ? ds_resp : slv_resp;
  assign Hrdata       = use_ds ? '0 : slv_rdata;
  assign Hmaster_data = master_q;
  assign timeout_err  = ds_timeout_err;

endmodule
